// File: rtl/result_mailbox_if.sv
// Bus bundle between the CPU data port / result consumer and the result mailbox.
// The slave modport is the mailbox side.
interface result_mailbox_if #(
  parameter int IDX_W = 3
);
  logic [31:0]      d_mem_addr;
  logic [31:0]      d_mem_wdata;
  logic [3:0]       d_mem_wen;
  logic [31:0]      d_mem_rdata;
  logic             mb_hit;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [31:0]      out_data;
  logic             done;
  logic             overflow;

  modport slave (
    input  d_mem_addr, d_mem_wdata, d_mem_wen, out_ready,
    output d_mem_rdata, mb_hit, out_valid, out_index, out_data, done, overflow
  );

  modport master (
    output d_mem_addr, d_mem_wdata, d_mem_wen, out_ready,
    input  d_mem_rdata, mb_hit, out_valid, out_index, out_data, done, overflow
  );
endinterface

// File: rtl/result_mailbox.sv
// Memory-mapped result slots; every slot store is also queued into a drain FIFO.
// state    | meaning
// IDLE     | program running, no completion request seen
// DRAIN    | completion requested, waiting for the FIFO to empty
// DONE     | completion requested and FIFO drained; terminal until reset
module result_mailbox #(
  parameter logic [31:0] BASE_ADDR  = 32'h200,
  parameter int          NUM_SLOTS  = 8,
  parameter int          FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  result_mailbox_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0]      SLOT_BYTES = 32'(4 * NUM_SLOTS);
  localparam logic [29:0]      CTRL_WORD  = 30'(NUM_SLOTS);
  localparam logic [29:0]      STAT_WORD  = 30'(NUM_SLOTS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic [31:0]      r_slot      [NUM_SLOTS];
  logic [IDX_W-1:0] r_fifo_idx  [FIFO_DEPTH];
  logic [31:0]      r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  state_t           r_state;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [31:0]      w_off;
  logic             w_slot_hit;
  logic             w_ctrl_hit;
  logic             w_stat_hit;
  logic             w_wr;
  logic [IDX_W-1:0] w_slot_idx;
  logic [31:0]      w_merged;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic             w_done_req;
  logic             w_valid;
  logic             w_done;
  logic [3:0]       w_cnt_field;

  // Decode on the offset from the base so the window compares stay base-independent.
  assign w_off      = bus.d_mem_addr - BASE_ADDR;
  assign w_slot_hit = (w_off < SLOT_BYTES);
  assign w_ctrl_hit = (w_off[31:2] == CTRL_WORD);
  assign w_stat_hit = (w_off[31:2] == STAT_WORD);
  assign w_slot_idx = w_off[IDX_W+1:2];
  assign w_wr       = |bus.d_mem_wen;

  always_comb begin
    w_merged = r_slot[w_slot_idx];
    for (int b = 0; b < 4; b++) begin
      if (bus.d_mem_wen[b]) begin
        w_merged[8*b +: 8] = bus.d_mem_wdata[8*b +: 8];
      end
    end
  end

  assign w_push     = w_wr & w_slot_hit;
  assign w_full     = (r_count == FULL_CNT);
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & bus.out_ready;
  // A full FIFO still accepts a push when its head leaves on the same edge.
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign w_done_req = w_wr & w_ctrl_hit & bus.d_mem_wdata[0];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push_ok && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_slot[i] <= '0;
      end
    end else if (w_push) begin
      r_slot[w_slot_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_idx[i]  <= '0;
        r_fifo_data[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_fifo_idx[r_wr_ptr]  <= w_slot_idx;
        r_fifo_data[r_wr_ptr] <= w_merged;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_done_req) begin
          w_state_nxt = w_valid ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (w_count_nxt == '0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_done      = (r_state == ST_DONE);
  assign w_cnt_field = 4'(r_count);

  always_comb begin
    bus.d_mem_rdata = '0;
    if (w_slot_hit) begin
      bus.d_mem_rdata = r_slot[w_slot_idx];
    end else if (w_stat_hit) begin
      bus.d_mem_rdata = {24'd0, w_cnt_field, 1'b0, w_done, r_overflow, w_valid};
    end
  end

  assign bus.mb_hit    = w_slot_hit | w_ctrl_hit | w_stat_hit;
  assign bus.out_valid = w_valid;
  assign bus.out_index = r_fifo_idx[r_rd_ptr];
  assign bus.out_data  = r_fifo_data[r_rd_ptr];
  assign bus.done      = w_done;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_result_mailbox.sv
// Scoreboard bench for result_mailbox: a behavioural model queues expected FIFO entries
// as stores are driven; a monitor queues observed transfers for in-order comparison.
module tb_result_mailbox;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  result_mailbox_if #(.IDX_W(3)) bus();

  result_mailbox #(
    .BASE_ADDR (32'h200),
    .NUM_SLOTS (8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [34:0] exp_q[$];
  logic [34:0] obs_q[$];
  logic [31:0] m_slot[8];
  int          m_count;
  int          m_state;   // 0 idle, 1 drain, 2 done
  logic        m_ovf;

  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      obs_q.push_back({bus.out_index, bus.out_data});
    end
  end

  task automatic reset_model();
    for (int i = 0; i < 8; i++) m_slot[i] = 32'd0;
    m_count = 0;
    m_state = 0;
    m_ovf   = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.d_mem_addr  = 32'd0;
    bus.d_mem_wdata = 32'd0;
    bus.d_mem_wen   = 4'b0000;
    bus.out_ready   = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Advance one clock while updating the model with whatever is on the bus.
  task automatic tick();
    logic        pop, push, acc, dreq;
    int          idx, cnt_pre;
    logic [31:0] mw;
    pop  = (m_count > 0) && bus.out_ready;
    push = (bus.d_mem_wen != 4'b0000) && (bus.d_mem_addr >= 32'h200) && (bus.d_mem_addr < 32'h220);
    dreq = (bus.d_mem_wen != 4'b0000) && (bus.d_mem_addr[31:2] == 30'h88) && bus.d_mem_wdata[0];
    acc  = 1'b0;
    cnt_pre = m_count;
    if (push) begin
      idx = int'((bus.d_mem_addr - 32'h200) >> 2);
      mw  = m_slot[idx];
      for (int b = 0; b < 4; b++) if (bus.d_mem_wen[b]) mw[8*b +: 8] = bus.d_mem_wdata[8*b +: 8];
      m_slot[idx] = mw;
      if (m_count < 4 || pop) begin
        exp_q.push_back({3'(idx), mw});
        acc = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_count = m_count + int'(acc) - int'(pop);
    if (m_state == 0 && dreq) m_state = (cnt_pre == 0) ? 2 : 1;
    else if (m_state == 1 && m_count == 0) m_state = 2;
    @(posedge clk);
    @(negedge clk);
    bus.d_mem_wen = 4'b0000;
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wen);
    bus.d_mem_addr  = addr;
    bus.d_mem_wdata = data;
    bus.d_mem_wen   = wen;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.d_mem_addr = 32'h200;
    bus.d_mem_wen  = 4'b0000;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid act=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done act=%b exp=0", bus.done); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow act=%b exp=0", bus.overflow); end
    n_cmp++; if (bus.out_data !== 32'd0) begin n_err++; $display("FAIL reset_out_data act=%h exp=0", bus.out_data); end
    n_cmp++; if (bus.out_index !== 3'd0) begin n_err++; $display("FAIL reset_out_index act=%0d exp=0", bus.out_index); end
    n_cmp++; if (bus.mb_hit !== 1'b1) begin n_err++; $display("FAIL reset_mb_hit act=%b exp=1", bus.mb_hit); end
    n_cmp++; if (bus.d_mem_rdata !== 32'd0) begin n_err++; $display("FAIL reset_slot0 act=%h exp=0", bus.d_mem_rdata); end
    bus.d_mem_addr = 32'h300;
    #1;
    n_cmp++; if (bus.mb_hit !== 1'b0) begin n_err++; $display("FAIL decode_miss_hit act=%b exp=0", bus.mb_hit); end
    apply_reset();
  endtask

  task automatic test_basic();
    logic [31:0] vals[5] = '{32'd6, 32'd9, 32'd11, 32'd15, 32'd19};
    logic [34:0] e, o;
    apply_reset();
    bus.out_ready = 1'b1;
    cpu_write(32'h300, 32'hDEAD, 4'hF);
    cpu_write(32'h1FC, 32'hBEEF, 4'hF);
    for (int i = 0; i < 5; i++) cpu_write(32'h200 + 32'(4*i), vals[i], 4'hF);
    repeat (4) tick();
    n_cmp++; if (obs_q.size() !== 5) begin n_err++; $display("FAIL basic_count act=%0d exp=5", obs_q.size()); end
    for (int i = 0; i < 5 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e || o !== {3'(i), vals[i]}) begin
        n_err++; $display("FAIL basic_order act=%0d/%h exp=%0d/%h", o[34:32], o[31:0], i, vals[i]);
      end
    end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow act=%b exp=0", bus.overflow); end
  endtask

  task automatic test_overflow();
    logic [34:0] e, o;
    logic [2:0]  h_idx;
    logic [31:0] h_data;
    apply_reset();
    for (int i = 0; i < 6; i++) cpu_write(32'h200 + 32'(4*i), 32'hA0 + 32'(i), 4'hF);
    bus.d_mem_addr = 32'h224;
    #1;
    n_cmp++; if (bus.d_mem_rdata[7:4] !== 4'(m_count)) begin n_err++; $display("FAIL ovf_status_count act=%0d exp=%0d", bus.d_mem_rdata[7:4], m_count); end
    n_cmp++; if (bus.d_mem_rdata[1] !== 1'b1 || bus.overflow !== m_ovf) begin n_err++; $display("FAIL ovf_flag act=%b/%b exp=1", bus.d_mem_rdata[1], bus.overflow); end
    bus.d_mem_addr = 32'h214;
    #1;
    n_cmp++; if (bus.d_mem_rdata !== 32'hA5) begin n_err++; $display("FAIL ovf_slot5 act=%h exp=a5", bus.d_mem_rdata); end
    h_idx  = bus.out_index;
    h_data = bus.out_data;
    repeat (2) tick();
    n_cmp++; if (bus.out_index !== h_idx || bus.out_data !== h_data || {h_idx, h_data} !== exp_q[0]) begin
      n_err++; $display("FAIL hold_head act=%0d/%h exp=%0d/%h", bus.out_index, bus.out_data, exp_q[0][34:32], exp_q[0][31:0]);
    end
    bus.out_ready = 1'b1;
    repeat (6) tick();
    n_cmp++; if (obs_q.size() !== 4) begin n_err++; $display("FAIL ovf_delivered act=%0d exp=4", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL ovf_order act=%0d/%h exp=%0d/%h", o[34:32], o[31:0], e[34:32], e[31:0]); end
    end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty act=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_byte_merge();
    logic [34:0] e, o;
    apply_reset();
    cpu_write(32'h208, 32'h11223344, 4'hF);
    cpu_write(32'h208, 32'hAABBCCDD, 4'b0010);
    bus.d_mem_addr = 32'h20A;
    #1;
    n_cmp++; if (bus.d_mem_rdata !== 32'h1122CC44) begin n_err++; $display("FAIL merge_slot act=%h exp=1122cc44", bus.d_mem_rdata); end
    bus.out_ready = 1'b1;
    repeat (3) tick();
    o = '0;
    n_cmp++; if (obs_q.size() !== 2) begin n_err++; $display("FAIL merge_count act=%0d exp=2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL merge_order act=%0d/%h exp=%0d/%h", o[34:32], o[31:0], e[34:32], e[31:0]); end
    end
    n_cmp++; if (o !== {3'd2, 32'h1122CC44}) begin n_err++; $display("FAIL merge_entry act=%0d/%h exp=2/1122cc44", o[34:32], o[31:0]); end
  endtask

  task automatic test_done();
    logic [34:0] e, o;
    apply_reset();
    cpu_write(32'h200, 32'h1, 4'hF);
    cpu_write(32'h21C, 32'h7, 4'hF);
    cpu_write(32'h220, 32'hFFFE, 4'hF);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_bit0_clear act=%b exp=0", bus.done); end
    cpu_write(32'h220, 32'h1, 4'hF);
    n_cmp++; if (bus.done !== (m_state == 2)) begin n_err++; $display("FAIL done_drain act=%b exp=0", bus.done); end
    bus.d_mem_addr = 32'h220;
    #1;
    n_cmp++; if (bus.d_mem_rdata !== 32'd0 || bus.mb_hit !== 1'b1) begin n_err++; $display("FAIL ctrl_read act=%h/%b exp=0/1", bus.d_mem_rdata, bus.mb_hit); end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_after_first act=%b exp=0", bus.done); end
    tick();
    n_cmp++; if (bus.done !== 1'b1 || m_state != 2) begin n_err++; $display("FAIL done_after_second act=%b exp=1", bus.done); end
    bus.d_mem_addr = 32'h224;
    #1;
    n_cmp++; if (bus.d_mem_rdata[2] !== 1'b1) begin n_err++; $display("FAIL status_done act=%b exp=1", bus.d_mem_rdata[2]); end
    cpu_write(32'h218, 32'h66, 4'hF);
    repeat (2) tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL done_terminal act=%b exp=1", bus.done); end
    n_cmp++; if (obs_q.size() !== 3) begin n_err++; $display("FAIL done_delivered act=%0d exp=3", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL done_order act=%0d/%h exp=%0d/%h", o[34:32], o[31:0], e[34:32], e[31:0]); end
    end
    apply_reset();
    cpu_write(32'h220, 32'h1, 4'hF);
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL done_direct act=%b exp=1", bus.done); end
  endtask

  task automatic test_back_to_back();
    logic [34:0] e, o;
    apply_reset();
    for (int i = 0; i < 4; i++) cpu_write(32'h200 + 32'(4*i), 32'hC0 + 32'(i), 4'hF);
    bus.out_ready = 1'b1;
    cpu_write(32'h210, 32'hC4, 4'hF);
    bus.d_mem_addr = 32'h224;
    #1;
    n_cmp++; if (bus.d_mem_rdata[7:4] !== 4'd4 || m_count != 4) begin n_err++; $display("FAIL pushpop_count act=%0d exp=4", bus.d_mem_rdata[7:4]); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL pushpop_overflow act=%b exp=0", bus.overflow); end
    bus.out_ready = 1'b0;
    cpu_write(32'h214, 32'hC5, 4'hF);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL drop_overflow act=%b exp=1", bus.overflow); end
    bus.out_ready = 1'b1;
    cpu_write(32'h220, 32'h1, 4'hF);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL pushpop_order act=%0d/%h exp=%0d/%h", o[34:32], o[31:0], e[34:32], e[31:0]); end
    end
    #2 rst_n = 1'b0;
    bus.d_mem_addr = 32'h224;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      n_err++; $display("FAIL midreset_flags act=%b%b%b exp=000", bus.out_valid, bus.done, bus.overflow);
    end
    n_cmp++; if (bus.out_data !== 32'd0 || bus.out_index !== 3'd0 || bus.d_mem_rdata !== 32'd0) begin
      n_err++; $display("FAIL midreset_data act=%h/%0d/%h exp=0/0/0", bus.out_data, bus.out_index, bus.d_mem_rdata);
    end
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    cpu_write(32'h204, 32'h77, 4'hF);
    repeat (3) tick();
    n_cmp++; if (obs_q.size() !== 1 || exp_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      n_err++; $display("FAIL post_reset_entry act=%0d entries exp=1 entry 1/77", obs_q.size());
    end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL post_reset_done act=%b exp=0", bus.done); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.d_mem_addr  = 32'd0;
    bus.d_mem_wdata = 32'd0;
    bus.d_mem_wen   = 4'b0000;
    bus.out_ready   = 1'b0;
    reset_model();
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_byte_merge();
    test_done();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
